// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the raster timing generator's control inputs and timing outputs.
//   master : the timing generator (receives pix_en/run, drives timing)
//   slave  : the consumer side (drives pix_en/run, receives timing)
// Signals:
//   pix_en          pixel-clock enable
//   run             request to generate frames
//   h_sync, v_sync  sync outputs, polarity set by the generator parameters
//   col_counter     current x
//   row_counter     current y
//   screen_inactive high outside the active area or when not running
//   line_start      one-enable pulse at x==0
//   frame_start     one-enable pulse at x==0, y==0
//   frame_count     completed-frame count, wraps
//   busy            generator is running or finishing its stop cycle
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CNT_W = 10,
    parameter int FRM_W = 8
);
    logic             pix_en;
    logic             run;
    logic             h_sync;
    logic             v_sync;
    logic [CNT_W-1:0] col_counter;
    logic [CNT_W-1:0] row_counter;
    logic             screen_inactive;
    logic             line_start;
    logic             frame_start;
    logic [FRM_W-1:0] frame_count;
    logic             busy;

    modport master (
        input  pix_en, run,
        output h_sync, v_sync, col_counter, row_counter, screen_inactive,
               line_start, frame_start, frame_count, busy
    );

    modport slave (
        output pix_en, run,
        input  h_sync, v_sync, col_counter, row_counter, screen_inactive,
               line_start, frame_start, frame_count, busy
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator with pixel-clock enable, programmable
// sync polarity and a run/stop controller that only changes on frame
// boundaries.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   tif  vga_timing_gen_if.master: pix_en/run in; syncs, counters, blank,
//        line/frame strobes, frame count and busy out
// All outputs are registered and decoded from the next x/y, so each output
// is coherent with col_counter/row_counter in the same cycle.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   CNT_W      = 10,
    parameter int   FRM_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master tif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Decode boundaries carry one extra bit so a sync region ending exactly
    // at the total (zero back porch) still compares correctly.
    localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_BEGIN  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_BEGIN  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] y_reg;
    logic [FRM_W-1:0] frame_count_reg;
    logic             h_sync_reg;
    logic             v_sync_reg;
    logic             inactive_reg;
    logic             line_start_reg;
    logic             frame_start_reg;
    logic             busy_reg;

    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic             x_wrap;
    logic             y_wrap;
    logic             frame_wrap;

    function automatic logic h_sync_level(input logic [CNT_W-1:0] xv);
        logic [CNT_W:0] xe;
        xe = {1'b0, xv};
        return ((xe >= HS_BEGIN) && (xe < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    endfunction

    function automatic logic v_sync_level(input logic [CNT_W-1:0] yv);
        logic [CNT_W:0] ye;
        ye = {1'b0, yv};
        return ((ye >= VS_BEGIN) && (ye < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    endfunction

    function automatic logic blank_level(input logic [CNT_W-1:0] xv,
                                         input logic [CNT_W-1:0] yv);
        return ({1'b0, xv} >= H_ACT_END) || ({1'b0, yv} >= V_ACT_END);
    endfunction

    // Raster position one enabled pixel ahead of the current one.
    always_comb begin
        x_wrap     = (x_reg == H_LAST);
        y_wrap     = (y_reg == V_LAST);
        frame_wrap = x_wrap && y_wrap;
        x_next     = x_wrap ? '0 : x_reg + CNT_W'(1);
        y_next     = y_reg;
        if (x_wrap) begin
            y_next = y_wrap ? '0 : y_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_count_reg <= '0;
            h_sync_reg      <= ~H_SYNC_POL;
            v_sync_reg      <= ~V_SYNC_POL;
            inactive_reg    <= 1'b1;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Start directly at the top-left pixel so the first RUN
                    // cycle already carries both strobes.
                    if (tif.pix_en && tif.run) begin
                        state_reg       <= ST_RUN;
                        x_reg           <= '0;
                        y_reg           <= '0;
                        h_sync_reg      <= h_sync_level('0);
                        v_sync_reg      <= v_sync_level('0);
                        inactive_reg    <= blank_level('0, '0);
                        line_start_reg  <= 1'b1;
                        frame_start_reg <= 1'b1;
                        busy_reg        <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (tif.pix_en) begin
                        if (frame_wrap) begin
                            frame_count_reg <= frame_count_reg + FRM_W'(1);
                        end
                        if (frame_wrap && !tif.run) begin
                            // Last pixel of the final frame: park the raster
                            // and present idle-looking outputs for one cycle.
                            state_reg       <= ST_STOPPING;
                            x_reg           <= '0;
                            y_reg           <= '0;
                            h_sync_reg      <= ~H_SYNC_POL;
                            v_sync_reg      <= ~V_SYNC_POL;
                            inactive_reg    <= 1'b1;
                            line_start_reg  <= 1'b0;
                            frame_start_reg <= 1'b0;
                        end else begin
                            x_reg           <= x_next;
                            y_reg           <= y_next;
                            h_sync_reg      <= h_sync_level(x_next);
                            v_sync_reg      <= v_sync_level(y_next);
                            inactive_reg    <= blank_level(x_next, y_next);
                            line_start_reg  <= (x_next == '0);
                            frame_start_reg <= (x_next == '0) && (y_next == '0);
                        end
                    end else begin
                        // Holding: position and levels stay, but strobes
                        // must not repeat for the same pixel.
                        line_start_reg  <= 1'b0;
                        frame_start_reg <= 1'b0;
                    end
                end

                ST_STOPPING: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg       <= ST_IDLE;
                    x_reg           <= '0;
                    y_reg           <= '0;
                    h_sync_reg      <= ~H_SYNC_POL;
                    v_sync_reg      <= ~V_SYNC_POL;
                    inactive_reg    <= 1'b1;
                    line_start_reg  <= 1'b0;
                    frame_start_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign tif.h_sync          = h_sync_reg;
    assign tif.v_sync          = v_sync_reg;
    assign tif.col_counter     = x_reg;
    assign tif.row_counter     = y_reg;
    assign tif.screen_inactive = inactive_reg;
    assign tif.line_start      = line_start_reg;
    assign tif.frame_start     = frame_start_reg;
    assign tif.frame_count     = frame_count_reg;
    assign tif.busy            = busy_reg;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480@60 Hz VGA counter block.
- Produces registered h_sync, v_sync, blanking, pixel coordinates and line/frame strobes for any mode set by parameters.
- Adds a pixel-clock enable, programmable sync polarity, and a run/stop state machine that only starts or stops on frame boundaries.
- Sits between the top-level clock/reset and the pixel pipeline, which consumes the coordinates and the blank flag.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of h_sync (0 = active-low)
- V_SYNC_POL, 0, asserted level of v_sync
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FRM_W, 8, frame counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pix_en  in  1  pixel-clock enable; counters and strobes advance only when high
- run  in  1  request to generate frames
- h_sync  out  1  horizontal sync, polarity set by H_SYNC_POL
- v_sync  out  1  vertical sync, polarity set by V_SYNC_POL
- col_counter  out  CNT_W  current x, 0..H_TOTAL-1
- row_counter  out  CNT_W  current y, 0..V_TOTAL-1
- screen_inactive  out  1  high outside the active area, or when not RUN
- line_start  out  1  one-enable pulse when x==0
- frame_start  out  1  one-enable pulse when x==0 and y==0
- frame_count  out  FRM_W  completed-frame count, wraps
- busy  out  1  high in RUN or STOPPING

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release): state IDLE; x=y=0; frame_count=0; h_sync=~H_SYNC_POL and v_sync=~V_SYNC_POL (deasserted); screen_inactive=1; line_start=frame_start=busy=0.
- States:
  - IDLE: counters held at 0; syncs deasserted; screen_inactive=1. Goes to RUN on the first pix_en cycle with run=1.
  - RUN: counters advance on each pix_en. If run=0 at the start of the cycle in which wrap (x=H_TOTAL-1, y=V_TOTAL-1, pix_en=1) occurs, go to STOPPING.
  - STOPPING: one cycle only. Counters are 0; outputs as IDLE; frame_count already incremented. Then go to IDLE.
  - run deasserted mid-frame: the frame completes normally. No partial frames.
  - run reasserted before the wrap: no effect; the block stays in RUN.
- Counting, in RUN with pix_en=1:
  - x increments; when x=H_TOTAL-1, x goes to 0 and y increments.
  - When y=V_TOTAL-1 at that same wrap, y goes to 0 and frame_count increments (modulo 2^FRM_W).
  - pix_en=0 holds all state and outputs. Strobes are not re-emitted while holding.
- Outputs are registered and decoded from the next x/y, so every output is coherent with col_counter/row_counter in the same cycle. Latency from the counter value to its decode is zero.
- Decodes:
  - h_sync asserted when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - v_sync asserted when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - screen_inactive = (x>=H_ACTIVE) | (y>=V_ACTIVE) | ~RUN.
  - line_start is high for exactly one pix_en-qualified cycle at x==0 in RUN. frame_start additionally requires y==0.
- First frame after IDLE->RUN starts at x=0, y=0 with line_start=frame_start=1 in the first RUN cycle.
- Async rst mid-frame: all outputs return to reset values immediately. Restart requires run.
- frame_count wrap: FF..FF goes to 0 without affecting timing.

Test Plan:
- Reset, then run=1 with pix_en=1 constant -> first RUN cycle x=0, y=0, frame_start=1; h_sync low for exactly 96 cycles starting at x=656; screen_inactive rises at x=640.
- Full frame at defaults -> 800*525=420000 cycles between frame_start pulses; v_sync low on y=490,491 only (1600 cycles); frame_count 0->1.
- pix_en toggled 1,0,1,0 -> counters advance every other clk; line period 1600 clk; line_start width equals one enabled cycle.
- run dropped at y=100 -> frame completes to x=799, y=524; one STOPPING cycle; then IDLE with busy=0, screen_inactive=1, syncs deasserted; frame_count incremented.
- Parameters H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, H_SYNC_POL=1 -> line 12 cycles; h_sync high at x=9,10; frame 84 cycles.
- rst asserted at x=300, y=200 between clock edges -> outputs at reset values without waiting for clk; after release, IDLE until run.
